instr_fetch_sequencer: RTL and testbench
========================================

# instr_fetch_sequencer

Owns the program counter and all access to the 32-entry instruction memory. After reset it accepts a program image over a valid/ready load channel and writes it into the memory's write port. It then fetches one instruction per cycle into a registered fetch-stage output, with stall, branch/jump redirect and halt control. It sits between the instruction memory and the decode stage of the MIPS pipeline.

## Interface
- WIDTH, 32, instruction word width
- InstructionCount, 32, memory depth; addresses are 5 bits, range 0..31
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  loader presents a word
- load_data  input  WIDTH  word to write
- load_last  input  1  qualifies the final word of the image
- load_ready  output  1  sequencer accepts a word this cycle
- imem_write_en  output  1  memory write strobe
- imem_write_addr  output  5  memory write address
- imem_write_data  output  WIDTH  memory write data
- imem_address  output  5  read address; drives the memory's currentAddress
- imem_read  output  1  read enable; drives readInstruction
- imem_instruction  input  WIDTH  combinational read data from memory
- stall  input  1  decode cannot accept; hold fetch
- redirect_valid  input  1  branch/jump taken
- redirect_target  input  5  new PC (word address)
- halt_req  input  1  stop fetching
- if_valid  output  1  if_instruction/if_pc hold a valid fetched instruction
- if_instruction  output  WIDTH  registered fetched word
- if_pc  output  5  address of if_instruction
- running  output  1  high in RUN state

## Operation
- States: LOAD, RUN, HALT. Reset enters LOAD and sets the following: load pointer to 0, pc to 0, prog_end to 0, if_valid to 0, if_instruction to 0, if_pc to 0, running to 0.
- LOAD
  - load_ready = 1; imem_read = 0.
  - On load_valid & load_ready: imem_write_en = 1, imem_write_addr = load pointer, imem_write_data = load_data (all combinational, same cycle); load pointer increments.
  - The load ends on an accepted beat with load_last = 1, or an accepted beat at address 31, whichever comes first. prog_end is set to that beat's address, pc to 0, and the state moves to RUN.
  - A beat at address 31 with load_last = 0 still ends the load.
  - stall, redirect and halt_req are ignored in LOAD.
- RUN
  - load_ready = 0; imem_write_en = 0; imem_address = pc; imem_read = !stall; running = 1.
  - Per-cycle priority: halt_req > redirect_valid > stall > normal fetch.
  - halt_req: state goes to HALT; if_valid goes to 0.
  - redirect_valid: pc goes to redirect_target; if_valid goes to 0 (squash the word read this cycle). This applies even when stall = 1.
  - stall (no redirect): pc, if_valid, if_instruction and if_pc all hold.
  - Normal fetch: if_instruction gets imem_instruction, if_pc gets pc, if_valid goes to 1. pc becomes 0 if pc == prog_end, else pc + 1.
  - PC arithmetic is 5-bit. A redirect target greater than prog_end is accepted; the PC then counts up and wraps 31 to 0.
- HALT
  - imem_read = 0, if_valid = 0, running = 0.
  - Only reset leaves HALT.
- Reset in any state, including mid-load, restarts in LOAD with an empty image. Memory contents are not cleared.

## Timing
- Memory read is combinational, so fetch latency is 1 cycle: the word at pc in cycle N appears on if_instruction in cycle N+1.
- Throughput is 1 instruction per cycle when stall = 0.
- Load writes occur in the same cycle the beat is accepted; 1 word per cycle.
- The first RUN fetch happens the cycle after the last load beat. if_valid first rises 1 cycle after that.
- A redirect in cycle N makes if_valid = 0 in N+1; the target's word appears in N+2.
- imem_write_en and imem_read are never high in the same cycle.

## Test plan
- Load 4 words (0xA0..0xA3, load_last on the 4th) with no stalls: addresses 0..3 are written; if_pc/if_instruction run 0/A0, 1/A1, 2/A2, 3/A3, 0/A0 … with if_valid continuously high from 2 cycles after the last beat.
- Load 32 words with load_last never asserted: the load ends after address 31 with prog_end = 31; the PC wraps 31 to 0.
- In RUN, assert stall for 3 cycles at pc = 2: if_pc stays 1, imem_read = 0 for those cycles, fetch resumes at 2.
- Assert redirect_valid = 1, redirect_target = 7 together with stall = 1: the next cycle has if_valid = 0, the following cycle has if_pc = 7; the redirect wins over the stall.
- Assert halt_req and redirect_valid in the same cycle: the state is HALT, if_valid = 0, imem_read = 0 thereafter; running = 0.
- Assert reset after 2 load beats, then load a 1-word image: load_ready = 1 after reset, the word is written at address 0, prog_end = 0, and if_pc stays at 0 repeatedly.

Source files
------------

// File: rtl/instr_fetch_sequencer_if.sv
// Bundle of the load channel, instruction-memory bus, pipeline control
// and fetch-stage outputs around the instruction fetch sequencer.
// The master modport is the sequencer's view; slave is everything around it.
interface instr_fetch_sequencer_if #(
    parameter int WIDTH = 32
);
    // program image load channel
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic             load_ready;

    // instruction memory write port
    logic             imem_write_en;
    logic [4:0]       imem_write_addr;
    logic [WIDTH-1:0] imem_write_data;

    // instruction memory read port (combinational read data)
    logic [4:0]       imem_address;
    logic             imem_read;
    logic [WIDTH-1:0] imem_instruction;

    // pipeline control from decode / execute
    logic             stall;
    logic             redirect_valid;
    logic [4:0]       redirect_target;
    logic             halt_req;

    // registered fetch-stage outputs toward decode
    logic             if_valid;
    logic [WIDTH-1:0] if_instruction;
    logic [4:0]       if_pc;
    logic             running;

    modport master (
        input  load_valid, load_data, load_last,
        input  imem_instruction,
        input  stall, redirect_valid, redirect_target, halt_req,
        output load_ready,
        output imem_write_en, imem_write_addr, imem_write_data,
        output imem_address, imem_read,
        output if_valid, if_instruction, if_pc, running
    );

    modport slave (
        output load_valid, load_data, load_last,
        output imem_instruction,
        output stall, redirect_valid, redirect_target, halt_req,
        input  load_ready,
        input  imem_write_en, imem_write_addr, imem_write_data,
        input  imem_address, imem_read,
        input  if_valid, if_instruction, if_pc, running
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC and the 32-entry instruction
// memory. Loads a program image over a valid/ready channel, then fetches one
// word per cycle into a registered fetch stage with stall, redirect and halt.
module instr_fetch_sequencer #(
    parameter int WIDTH            = 32,
    parameter int InstructionCount = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_fetch_sequencer_if.master bus
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // highest memory address; a beat here always ends the load
    localparam logic [4:0] LAST_ADDR = 5'(InstructionCount - 1);

    logic [1:0]       state;
    logic [4:0]       load_ptr;
    logic [4:0]       pc;
    logic [4:0]       prog_end;
    logic             if_valid;
    logic [WIDTH-1:0] if_instruction;
    logic [4:0]       if_pc;

    logic             in_load;
    logic             in_run;
    logic             load_fire;
    logic             load_done;
    logic [4:0]       pc_seq_next;

    // decode state, detect accepted/final load beats and compute the
    // sequential PC successor (wrap to 0 after the last program word)
    always_comb begin
        in_load     = (state == ST_LOAD);
        in_run      = (state == ST_RUN);
        load_fire   = in_load && bus.load_valid;
        load_done   = load_fire && (bus.load_last || (load_ptr == LAST_ADDR));
        pc_seq_next = (pc == prog_end) ? 5'd0 : pc + 5'd1;
    end

    // load writes go straight to the memory in the cycle the beat is accepted
    assign bus.load_ready      = in_load;
    assign bus.imem_write_en   = load_fire;
    assign bus.imem_write_addr = load_ptr;
    assign bus.imem_write_data = bus.load_data;

    // reads only in RUN and only when decode can take the word
    assign bus.imem_address    = pc;
    assign bus.imem_read       = in_run && !bus.stall;

    assign bus.if_valid        = if_valid;
    assign bus.if_instruction  = if_instruction;
    assign bus.if_pc           = if_pc;
    assign bus.running         = in_run;

    // LOAD/RUN/HALT sequencing plus the fetch-stage register
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_LOAD;
            load_ptr       <= 5'd0;
            pc             <= 5'd0;
            prog_end       <= 5'd0;
            if_valid       <= 1'b0;
            if_instruction <= '0;
            if_pc          <= 5'd0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        load_ptr <= load_ptr + 5'd1;
                    end
                    if (load_done) begin
                        prog_end <= load_ptr;
                        pc       <= 5'd0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.halt_req) begin
                        state    <= ST_HALT;
                        if_valid <= 1'b0;
                    end else if (bus.redirect_valid) begin
                        pc       <= bus.redirect_target;
                        if_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        if_instruction <= bus.imem_instruction;
                        if_pc          <= pc;
                        if_valid       <= 1'b1;
                        pc             <= pc_seq_next;
                    end
                end
                ST_HALT: begin
                    if_valid <= 1'b0;
                end
                default: begin
                    state    <= ST_HALT;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed scenarios with
// literal expectations, then randomized load/run rounds checked every cycle
// against a behavioural model of the sequencer.
module tb_instr_fetch_sequencer;

    localparam int WIDTH = 32;

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    instr_fetch_sequencer_if #(.WIDTH(WIDTH)) bus ();

    instr_fetch_sequencer #(.WIDTH(WIDTH), .InstructionCount(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] fill_pattern(input int i);
        return 32'hDEAD_0000 | 32'(i);
    endfunction

    // instruction memory: combinational read, written by the DUT's write port
    logic [31:0] mem [32];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] = fill_pattern(i);
            mem_init = 1'b1;
        end else if (bus.imem_write_en) begin
            mem[bus.imem_write_addr] <= bus.imem_write_data;
        end
    end

    assign bus.imem_instruction = mem[bus.imem_address];

    // behavioural model: program image array and fetch stage
    int          m_mode;
    logic [4:0]  m_ptr, m_pc, m_end, m_ifpc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] image [32];
    bit          image_init = 1'b0;
    bit          model_live = 1'b0;

    // advance the model on each clock edge from the inputs the DUT sees
    always @(posedge clk) begin
        if (reset) begin
            if (!image_init) begin
                for (int i = 0; i < 32; i++) image[i] = fill_pattern(i);
                image_init = 1'b1;
            end
            m_mode     = M_LOAD;
            m_ptr      = 0;
            m_pc       = 0;
            m_end      = 0;
            m_valid    = 0;
            m_instr    = 0;
            m_ifpc     = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (m_mode == M_LOAD) begin
                if (bus.load_valid) begin
                    image[m_ptr] = bus.load_data;
                    if (bus.load_last || m_ptr == 5'd31) begin
                        m_end  = m_ptr;
                        m_pc   = 0;
                        m_mode = M_RUN;
                    end
                    m_ptr = 5'((int'(m_ptr) + 1) % 32);
                end
            end else if (m_mode == M_RUN) begin
                if (bus.halt_req) begin
                    m_mode  = M_HALT;
                    m_valid = 0;
                end else if (bus.redirect_valid) begin
                    m_pc    = bus.redirect_target;
                    m_valid = 0;
                end else if (!bus.stall) begin
                    m_instr = image[m_pc];
                    m_ifpc  = m_pc;
                    m_valid = 1;
                    m_pc    = (m_pc == m_end) ? 5'd0 : 5'((int'(m_pc) + 1) % 32);
                end
            end else begin
                m_valid = 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        if (model_live) begin
            check_output("load_ready", 32'(bus.load_ready), 32'(m_mode == M_LOAD));
            check_output("imem_write_en", 32'(bus.imem_write_en),
                         32'(m_mode == M_LOAD && bus.load_valid));
            if (m_mode == M_LOAD && bus.load_valid) begin
                check_output("imem_write_addr", 32'(bus.imem_write_addr), 32'(m_ptr));
                check_output("imem_write_data", bus.imem_write_data, bus.load_data);
            end
            check_output("imem_read", 32'(bus.imem_read), 32'(m_mode == M_RUN && !bus.stall));
            if (m_mode == M_RUN)
                check_output("imem_address", 32'(bus.imem_address), 32'(m_pc));
            check_output("running", 32'(bus.running), 32'(m_mode == M_RUN));
            check_output("if_valid", 32'(bus.if_valid), 32'(m_valid));
            if (m_valid) begin
                check_output("if_instruction", bus.if_instruction, m_instr);
                check_output("if_pc", 32'(bus.if_pc), 32'(m_ifpc));
            end
            check_output("rd_wr_exclusive", 32'(bus.imem_write_en & bus.imem_read), 32'd0);
        end
    end

    task automatic apply_stimulus(input logic lv, input logic [31:0] ld, input logic ll,
                                  input logic st, input logic rv, input logic [4:0] rt,
                                  input logic hr);
        bus.load_valid      = lv;
        bus.load_data       = ld;
        bus.load_last       = ll;
        bus.stall           = st;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.halt_req        = hr;
    endtask

    task automatic idle_inputs();
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // one accepted load beat, with a literal check of the write address
    task automatic load_beat(input logic [31:0] data, input logic last, input int addr);
        apply_stimulus(1'b1, data, last, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        check_output("lit_write_en", 32'(bus.imem_write_en), 32'd1);
        check_output("lit_write_addr", 32'(bus.imem_write_addr), 32'(addr));
        step();
        idle_inputs();
    endtask

    task automatic load_a_image();
        for (int i = 0; i < 4; i++) load_beat(32'hA0 + 32'(i), i == 3, i);
    endtask

    task automatic random_control();
        bus.stall           = ($urandom % 4) == 0;
        bus.redirect_valid  = ($urandom % 8) == 0;
        bus.redirect_target = 5'($urandom % 32);
        bus.halt_req        = ($urandom % 40) == 0;
    endtask

    initial begin
        int len;
        int gaps;
        bit no_last;

        reset = 1'b1;
        idle_inputs();

        // reset state
        do_reset();
        #1;
        check_output("reset_load_ready", 32'(bus.load_ready), 32'd1);
        check_output("reset_if_valid", 32'(bus.if_valid), 32'd0);
        check_output("reset_if_instruction", bus.if_instruction, 32'd0);
        check_output("reset_if_pc", 32'(bus.if_pc), 32'd0);
        check_output("reset_running", 32'(bus.running), 32'd0);

        // four-word image, free-running fetch wraps at prog_end
        load_a_image();
        check_output("run_running", 32'(bus.running), 32'd1);
        check_output("run_first_valid", 32'(bus.if_valid), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_output("seq_valid", 32'(bus.if_valid), 32'd1);
            check_output("seq_pc", 32'(bus.if_pc), 32'((k - 1) % 4));
            check_output("seq_instr", bus.if_instruction, 32'hA0 + 32'((k - 1) % 4));
        end

        // three-cycle stall with pc at 2
        do_reset();
        load_a_image();
        step();
        step();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output("stall_imem_read", 32'(bus.imem_read), 32'd0);
            step();
            check_output("stall_if_pc", 32'(bus.if_pc), 32'd1);
            check_output("stall_if_valid", 32'(bus.if_valid), 32'd1);
        end
        bus.stall = 1'b0;
        step();
        check_output("resume_if_pc", 32'(bus.if_pc), 32'd2);
        check_output("resume_instr", bus.if_instruction, 32'hA2);

        // redirect to 7 together with stall: redirect wins
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
        #1;
        check_output("redir_imem_read", 32'(bus.imem_read), 32'd0);
        step();
        idle_inputs();
        check_output("redir_squash", 32'(bus.if_valid), 32'd0);
        step();
        check_output("redir_valid", 32'(bus.if_valid), 32'd1);
        check_output("redir_if_pc", 32'(bus.if_pc), 32'd7);
        check_output("redir_instr", bus.if_instruction, 32'hDEAD_0007);

        // halt together with redirect: halt wins and sticks
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1);
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output("halt_imem_read", 32'(bus.imem_read), 32'd0);
            check_output("halt_if_valid", 32'(bus.if_valid), 32'd0);
            check_output("halt_running", 32'(bus.running), 32'd0);
            step();
        end

        // reset mid-load, then a one-word image
        do_reset();
        load_beat(32'h11, 1'b0, 0);
        load_beat(32'h22, 1'b0, 1);
        do_reset();
        #1;
        check_output("reload_ready", 32'(bus.load_ready), 32'd1);
        load_beat(32'h55, 1'b1, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_output("one_word_valid", 32'(bus.if_valid), 32'd1);
            check_output("one_word_pc", 32'(bus.if_pc), 32'd0);
            check_output("one_word_instr", bus.if_instruction, 32'h55);
        end

        // 32-word image without load_last: ends at address 31, PC wraps
        do_reset();
        for (int i = 0; i < 32; i++) load_beat(32'hB000 + 32'(i), 1'b0, i);
        check_output("full_running", 32'(bus.running), 32'd1);
        for (int k = 1; k <= 33; k++) begin
            step();
            check_output("full_pc", 32'(bus.if_pc), 32'((k - 1) % 32));
            check_output("full_instr", bus.if_instruction, 32'hB000 + 32'((k - 1) % 32));
        end

        // randomized rounds checked by the model
        for (int r = 0; r < 12; r++) begin
            do_reset();
            if (($urandom % 4) == 0) begin
                for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                    apply_stimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
                    step();
                end
                do_reset();
            end
            len     = int'($urandom_range(1, 32));
            no_last = ($urandom % 2) == 1;
            for (int b = 0; b < len; b++) begin
                gaps = int'($urandom % 3);
                for (int g = 0; g < gaps; g++) begin
                    bus.load_valid = 1'b0;
                    bus.load_last  = ($urandom % 2) == 1;
                    random_control();
                    step();
                end
                bus.load_valid = 1'b1;
                bus.load_data  = $urandom;
                bus.load_last  = (b == len - 1) && !(len == 32 && no_last);
                random_control();
                step();
            end
            idle_inputs();
            for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
                random_control();
                step();
            end
            idle_inputs();
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
